pixel_dispatch_ctrl: RTL and testbench

- Sequences the x/y pixel counters of the work dispatcher and hands each pixel coordinate of a Julia-set frame to one of NUM_CORES compute cores.
- Scans the frame in raster order: x is fastest and wraps at width; y advances on each x wrap.
- Shares the coordinate stream among cores by round-robin arbitration over core_ready.
- Signals frame completion once every pixel is issued and all cores are idle again.

---
 rtl/work_dispatch_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/pixel_dispatch_ctrl.sv | 89 ++++++++
 tb/tb_pixel_dispatch_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/work_dispatch_pkg.sv
// work_dispatch_pkg: shared dispatcher types and default sizes
// Shared with the compute cores and the frame-buffer writer.
package work_dispatch_pkg;
    localparam int DEF_X_BITS    = 10;
    localparam int DEF_Y_BITS    = 10;
    localparam int DEF_NUM_CORES = 4;
    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, search starts at ptr and ascends modulo NUM_CORES
// Ports: req  - request vector (core_ready)
//        ptr  - index searched first
//        en   - grant enable; gnt is zero when low
//        gnt  - one-hot grant
import work_dispatch_pkg::*;
module rr_arbiter #(
    parameter int  NUM_CORES = DEF_NUM_CORES,
    localparam int PW        = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [PW-1:0]        ptr,
    input  logic                 en,
    output logic [NUM_CORES-1:0] gnt
);
    logic          found;
    logic [PW-1:0] idx;
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = PW'((int'(ptr) + i) % NUM_CORES);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pixel_dispatch_ctrl.sv
// pixel_dispatch_ctrl: raster-scans a frame and hands each pixel to a ready core round-robin
// Ports: start/abort           - frame control (abort wins)
//        width_m1/height_m1    - frame size minus 1, latched on accepted start
//        core_ready            - per-core idle flags
//        grant                 - one-hot, core i takes px_x/px_y this cycle
//        px_x/px_y             - registered current pixel
//        busy                  - high in DISPATCH and DRAIN
//        done                  - one-cycle pulse, first cycle back in IDLE
import work_dispatch_pkg::*;
module pixel_dispatch_ctrl #(
    parameter int  X_BITS    = DEF_X_BITS,
    parameter int  Y_BITS    = DEF_Y_BITS,
    parameter int  NUM_CORES = DEF_NUM_CORES,
    localparam int PW        = $clog2(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [X_BITS-1:0]    width_m1,
    input  logic [Y_BITS-1:0]    height_m1,
    input  logic [NUM_CORES-1:0] core_ready,
    output logic [NUM_CORES-1:0] grant,
    output logic [X_BITS-1:0]    px_x,
    output logic [Y_BITS-1:0]    px_y,
    output logic                 busy,
    output logic                 done
);
    state_t            state, state_nxt;
    logic [X_BITS-1:0] w_lat;
    logic [Y_BITS-1:0] h_lat;
    logic [PW-1:0]     ptr, gidx, ptr_nxt;
    logic              xfer, last, accept, finish, x_end;

    rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .req (core_ready),
        .ptr (ptr),
        .en  (state == DISPATCH && !abort),
        .gnt (grant)
    );

    assign xfer    = |grant;
    assign x_end   = px_x == w_lat;
    assign last    = x_end && px_y == h_lat;
    assign accept  = state == IDLE && start && !abort;
    assign finish  = state == DRAIN && !abort && &core_ready;
    assign busy    = state != IDLE;
    assign ptr_nxt = (gidx == PW'(NUM_CORES - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_CORES; i++)
            if (grant[i]) gidx = PW'(i);
    end

    // xfer is only possible in DISPATCH, so it needs no state qualifier here
    always_comb begin
        state_nxt = state;
        state_nxt = abort           ? IDLE     :
                    accept          ? DISPATCH :
                    (xfer && last)  ? DRAIN    :
                    finish          ? IDLE     : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            px_x  <= '0;
            px_y  <= '0;
            w_lat <= '0;
            h_lat <= '0;
            ptr   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= finish;
            if (accept) begin
                w_lat <= width_m1;
                h_lat <= height_m1;
                px_x  <= '0;
                px_y  <= '0;
            end else if (xfer && !last) begin
                px_x <= x_end ? '0 : px_x + 1'b1;
                if (x_end) px_y <= px_y + 1'b1;
            end
            if (xfer) ptr <= ptr_nxt;
        end
    end
endmodule

// File: tb/tb_pixel_dispatch_ctrl.sv
// tb_pixel_dispatch_ctrl: directed table and sequence checks for pixel_dispatch_ctrl
module tb_pixel_dispatch_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] width_m1 = '0;
    logic [9:0] height_m1 = '0;
    logic [3:0] core_ready = 4'hf;
    logic [3:0] grant;
    logic [9:0] px_x, px_y;
    logic       busy, done;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    pixel_dispatch_ctrl #(.X_BITS(10), .Y_BITS(10), .NUM_CORES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .width_m1   (width_m1),
        .height_m1  (height_m1),
        .core_ready (core_ready),
        .grant      (grant),
        .px_x       (px_x),
        .px_y       (px_y),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic       r, s, a;
        logic [9:0] w, h;
        logic [3:0] cr;
        logic [3:0] g;
        logic [9:0] x, y;
        logic       b, d;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, s, a, input logic [9:0] w, h, input logic [3:0] cr,
                       input logic [3:0] g, input logic [9:0] x, y, input logic b, d);
        vec_t v;
        v = '{r, s, a, w, h, cr, g, x, y, b, d};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else pass_cnt++;
    endtask

    // apply inputs just after a rising edge, return at the following falling edge for sampling
    task automatic drive(input logic r, s, a, input logic [9:0] w, h, input logic [3:0] cr);
        @(posedge clk);
        #1;
        rst = r; start = s; abort = a; width_m1 = w; height_m1 = h; core_ready = cr;
        @(negedge clk);
    endtask

    int         cnt[4];
    int         ng, nd;
    logic [3:0] cr_m;

    initial begin
        // reset, abort-wins, single-pixel frame, fairness on 4'b1010 with start ignored in DISPATCH
        add(1,0,0, 0,0, 4'hf, 4'h0, 0,0, 0,0);
        add(1,0,0, 0,0, 4'hf, 4'h0, 0,0, 0,0);
        add(0,0,0, 0,0, 4'hf, 4'h0, 0,0, 0,0);
        add(0,0,0, 0,0, 4'hf, 4'h0, 0,0, 0,0);
        add(0,1,1, 1,1, 4'hf, 4'h0, 0,0, 0,0);
        add(0,0,0, 1,1, 4'hf, 4'h0, 0,0, 0,0);
        add(0,1,0, 0,0, 4'hf, 4'h0, 0,0, 0,0);
        add(0,0,0, 0,0, 4'hf, 4'h1, 0,0, 1,0);
        add(0,0,0, 0,0, 4'he, 4'h0, 0,0, 1,0);
        add(0,0,0, 0,0, 4'he, 4'h0, 0,0, 1,0);
        add(0,0,0, 0,0, 4'hf, 4'h0, 0,0, 1,0);
        add(0,0,0, 0,0, 4'hf, 4'h0, 0,0, 0,1);
        add(0,0,0, 0,0, 4'hf, 4'h0, 0,0, 0,0);
        add(0,1,0, 1,1, 4'ha, 4'h0, 0,0, 0,0);
        add(0,0,0, 1,1, 4'ha, 4'h2, 0,0, 1,0);
        add(0,1,0, 3,3, 4'ha, 4'h8, 1,0, 1,0);
        add(0,0,0, 3,3, 4'ha, 4'h2, 0,1, 1,0);
        add(0,0,0, 3,3, 4'ha, 4'h8, 1,1, 1,0);
        add(0,0,0, 3,3, 4'ha, 4'h0, 1,1, 1,0);
        add(0,0,0, 3,3, 4'hf, 4'h0, 1,1, 1,0);
        add(0,0,0, 3,3, 4'hf, 4'h0, 1,1, 0,1);
        add(0,0,0, 3,3, 4'hf, 4'h0, 1,1, 0,0);
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].w, tbl[i].h, tbl[i].cr);
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_px_x", i), 32'(px_x), 32'(tbl[i].x));
            chk($sformatf("tbl%0d_px_y", i), 32'(px_y), 32'(tbl[i].y));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].d));
        end

        // full 4x3 frame, each core busy for 3 cycles after its grant
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        drive(0,1,0, 3,2, 4'hf);
        chk("frame_busy_at_start", 32'(busy), 0);
        ng = 0;
        nd = 0;
        for (int c = 0; c < 80 && nd == 0; c++) begin
            for (int i = 0; i < 4; i++) cr_m[i] = cnt[i] == 0;
            drive(0,0,0, 3,2, cr_m);
            if (done) begin
                nd++;
                chk("frame_busy_at_done", 32'(busy), 0);
            end else chk("frame_busy", 32'(busy), 1);
            if (grant != 4'h0) begin
                chk("frame_grant", 32'(grant), 32'(4'h1 << (ng % 4)));
                chk("frame_px", {12'h0, px_y, px_x}, {12'h0, 10'(ng / 4), 10'(ng % 4)});
                ng++;
            end
            for (int i = 0; i < 4; i++) cnt[i] = grant[i] ? 3 : (cnt[i] > 0 ? cnt[i] - 1 : 0);
        end
        chk("frame_grants", ng, 12);
        chk("frame_done_seen", nd, 1);
        drive(0,0,0, 3,2, 4'hf);
        chk("frame_done_pulse", 32'(done), 0);

        // stall mid-frame for 10 cycles
        drive(0,1,0, 3,0, 4'hf);
        drive(0,0,0, 3,0, 4'hf);
        chk("stall_g0", 32'(grant), 32'h1);
        for (int c = 0; c < 10; c++) begin
            drive(0,0,0, 3,0, 4'h0);
            chk("stall_grant", 32'(grant), 0);
            chk("stall_px", {12'h0, px_y, px_x}, 32'h1);
            chk("stall_busy", 32'(busy), 1);
        end
        drive(0,0,0, 3,0, 4'hf);
        chk("stall_resume_grant", 32'(grant), 32'h2);
        chk("stall_resume_px", {12'h0, px_y, px_x}, 32'h1);
        drive(0,0,0, 3,0, 4'hf);
        chk("stall_g2", 32'(grant), 32'h4);
        chk("stall_px2", {12'h0, px_y, px_x}, 32'h2);
        drive(0,0,0, 3,0, 4'hf);
        chk("stall_g3", 32'(grant), 32'h8);
        chk("stall_px3", {12'h0, px_y, px_x}, 32'h3);
        drive(0,0,0, 3,0, 4'hf);
        chk("stall_drain_grant", 32'(grant), 0);
        chk("stall_drain_done", 32'(done), 0);
        drive(0,0,0, 3,0, 4'hf);
        chk("stall_done", 32'(done), 1);

        // abort at (2,1) of a 4x4 frame, then a 2x1 frame
        drive(0,1,0, 3,3, 4'hf);
        for (int k = 0; k < 6; k++) begin
            drive(0,0,0, 3,3, 4'hf);
            chk("abort_pre_grant", 32'(grant), 32'(4'h1 << (k % 4)));
            chk("abort_pre_px", {12'h0, px_y, px_x}, {12'h0, 10'(k / 4), 10'(k % 4)});
        end
        drive(0,0,1, 3,3, 4'hf);
        chk("abort_grant", 32'(grant), 0);
        chk("abort_px", {12'h0, px_y, px_x}, {12'h0, 10'd1, 10'd2});
        drive(0,0,0, 3,3, 4'hf);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_idle_grant", 32'(grant), 0);
        chk("abort_no_done", 32'(done), 0);
        chk("abort_px_hold", {12'h0, px_y, px_x}, {12'h0, 10'd1, 10'd2});
        drive(0,0,0, 3,3, 4'hf);
        chk("abort_no_done2", 32'(done), 0);
        drive(0,1,0, 1,0, 4'hf);
        chk("restart_idle", 32'(busy), 0);
        drive(0,0,0, 1,0, 4'hf);
        chk("restart_g0", 32'(grant), 32'h4);
        chk("restart_px0", {12'h0, px_y, px_x}, 0);
        drive(0,0,0, 1,0, 4'hf);
        chk("restart_g1", 32'(grant), 32'h8);
        chk("restart_px1", {12'h0, px_y, px_x}, 32'h1);
        drive(0,0,0, 1,0, 4'hf);
        chk("restart_drain", 32'(busy), 1);
        chk("restart_drain_grant", 32'(grant), 0);
        drive(0,0,0, 1,0, 4'hf);
        chk("restart_done", 32'(done), 1);
        chk("restart_idle_end", 32'(busy), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
